// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch
// Purpose  : IF stage of a 5-stage MIPS pipeline. Holds the PC register, a
//            loadable word-addressed instruction memory and the IF/ID
//            pipeline register feeding decode. Handles PC redirect, hazard
//            stalls, bubble insertion, HALT detection and a RUN cycle count.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   i_clk            in   1        clock, rising edge
//   i_rst            in   1        synchronous active-high reset
//   i_run            in   1        start execution (IDLE -> RUN)
//   i_stall          in   1        hold PC and IF/ID
//   i_flush          in   1        replace IF/ID with a bubble
//   i_flg_pc_src     in   1        redirect PC to i_pc_target
//   i_pc_target      in   NBITS    jump/branch target address
//   i_imem_wr_en     in   1        program-load write strobe (IDLE only)
//   i_imem_wr_addr   in   log2(D)  word index
//   i_imem_wr_data   in   32       instruction word
//   o_pc             out  NBITS    PC+4 of the instruction in IF/ID
//   o_instruction    out  32       instruction in IF/ID
//   o_valid          out  1        IF/ID holds a real instruction
//   o_halted         out  1        high in HALTED state
//   o_cycle_count    out  32       cycles spent in RUN
// ============================================================================
module instruction_fetch #(
  parameter int          NBITS      = 32,
  parameter int          MEM_DEPTH  = 256,
  parameter logic [31:0] HALT_INSTR = 32'hFC000000
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_run,
  input  logic                         i_stall,
  input  logic                         i_flush,
  input  logic                         i_flg_pc_src,
  input  logic [NBITS-1:0]             i_pc_target,
  input  logic                         i_imem_wr_en,
  input  logic [$clog2(MEM_DEPTH)-1:0] i_imem_wr_addr,
  input  logic [31:0]                  i_imem_wr_data,
  output logic [NBITS-1:0]             o_pc,
  output logic [31:0]                  o_instruction,
  output logic                         o_valid,
  output logic                         o_halted,
  output logic [31:0]                  o_cycle_count
);

  localparam int AW = $clog2(MEM_DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [NBITS-1:0] pc, pc_next, pc_plus4, target_aligned;
  logic [NBITS-1:0] ifid_pc, ifid_pc_next;
  logic [31:0]      ifid_instr, ifid_instr_next;
  logic             ifid_valid, ifid_valid_next;
  logic [31:0]      cycle_count, cycle_count_next;
  logic [31:0]      fetch_word;
  logic [AW-1:0]    rd_idx;
  logic             load_ifid, halt_hit;

  logic [31:0] mem [MEM_DEPTH];

  // Word index drops PC[1:0]; upper PC bits wrap the address modulo depth.
  assign rd_idx         = pc[AW+1:2];
  assign fetch_word     = mem[rd_idx];
  assign pc_plus4       = pc + NBITS'(4);
  assign target_aligned = i_pc_target & ~NBITS'(3);

  // Program load only in IDLE; reset blocks the write as well.
  always_ff @(posedge i_clk) begin
    if (!i_rst && state == IDLE && i_imem_wr_en) begin
      mem[i_imem_wr_addr] <= i_imem_wr_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= IDLE;
      pc          <= '0;
      ifid_pc     <= '0;
      ifid_instr  <= '0;
      ifid_valid  <= 1'b0;
      cycle_count <= '0;
    end else begin
      state       <= state_next;
      pc          <= pc_next;
      ifid_pc     <= ifid_pc_next;
      ifid_instr  <= ifid_instr_next;
      ifid_valid  <= ifid_valid_next;
      cycle_count <= cycle_count_next;
    end
  end

  // The fetched word enters IF/ID only when neither flushed nor stalled.
  // A HALT stops fetch only if it really lands there and no redirect
  // is steering the PC away in the same cycle.
  assign load_ifid = !i_flush && !i_stall;
  assign halt_hit  = load_ifid && !i_flg_pc_src && (fetch_word == HALT_INSTR);

  always_comb begin
    state_next       = state;
    pc_next          = pc;
    ifid_pc_next     = ifid_pc;
    ifid_instr_next  = ifid_instr;
    ifid_valid_next  = ifid_valid;
    cycle_count_next = cycle_count;
    case (state)
      IDLE: begin
        if (i_run) state_next = RUN;
      end
      RUN: begin
        cycle_count_next = cycle_count + 32'd1;
        if (i_flush) begin
          ifid_pc_next    = '0;
          ifid_instr_next = '0;
          ifid_valid_next = 1'b0;
        end else if (load_ifid) begin
          ifid_pc_next    = pc_plus4;
          ifid_instr_next = fetch_word;
          ifid_valid_next = 1'b1;
        end
        if (i_flg_pc_src) begin
          pc_next = target_aligned;
        end else if (halt_hit) begin
          state_next = HALTED;
        end else if (!i_stall) begin
          pc_next = pc_plus4;
        end
      end
      HALTED: begin
        // A stall keeps the HALT visible to decode until it is released.
        if (!i_stall) begin
          ifid_pc_next    = '0;
          ifid_instr_next = '0;
          ifid_valid_next = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign o_pc          = ifid_pc;
  assign o_instruction = ifid_instr;
  assign o_valid       = ifid_valid;
  assign o_halted      = (state == HALTED);
  assign o_cycle_count = cycle_count;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_instruction_fetch
// Purpose  : Self-checking bench for instruction_fetch: a directed vector
//            table for the program/stall/redirect/wrap/halt/reset cases,
//            then randomized traffic compared against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch;

  localparam logic [31:0] HALT = 32'hFC000000;

  logic        clk = 1'b0;
  logic        rst, run, stall, flush, pc_src, wr_en;
  logic [31:0] pc_target, wr_data;
  logic [7:0]  wr_addr;
  logic [31:0] pc_o, instr_o, count_o;
  logic        valid_o, halted_o;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  instruction_fetch #(.NBITS(32), .MEM_DEPTH(256), .HALT_INSTR(HALT)) dut (
    .i_clk(clk), .i_rst(rst), .i_run(run), .i_stall(stall), .i_flush(flush),
    .i_flg_pc_src(pc_src), .i_pc_target(pc_target), .i_imem_wr_en(wr_en),
    .i_imem_wr_addr(wr_addr), .i_imem_wr_data(wr_data),
    .o_pc(pc_o), .o_instruction(instr_o), .o_valid(valid_o),
    .o_halted(halted_o), .o_cycle_count(count_o)
  );

  // ---------------- behavioural reference model ----------------
  logic [31:0] m_mem [256];
  bit          m_running, m_halted;
  logic [31:0] m_pc, m_opc, m_oins, m_cnt;
  bit          m_ov;

  task automatic model_step();
    logic [31:0] w;
    if (rst) begin
      m_running = 0; m_halted = 0; m_pc = 0; m_opc = 0; m_oins = 0; m_ov = 0; m_cnt = 0;
    end else if (m_halted) begin
      if (!stall) begin m_opc = 0; m_oins = 0; m_ov = 0; end
    end else if (m_running) begin
      w = m_mem[(m_pc / 4) % 256];
      m_cnt = m_cnt + 1;
      if (flush) begin
        m_opc = 0; m_oins = 0; m_ov = 0;
      end else if (!stall) begin
        m_opc = m_pc + 4; m_oins = w; m_ov = 1;
      end
      if (pc_src) m_pc = pc_target - (pc_target % 4);
      else if (!flush && !stall && w == HALT) begin m_running = 0; m_halted = 1; end
      else if (!stall) m_pc = m_pc + 4;
    end else begin
      if (wr_en) m_mem[wr_addr] = wr_data;
      if (run) m_running = 1;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic check_outs(input string tag, input logic [31:0] e_pc, input logic [31:0] e_ins,
                            input logic e_v, input logic e_h, input logic [31:0] e_cnt);
    check({tag, " pc"},     pc_o,           e_pc);
    check({tag, " instr"},  instr_o,        e_ins);
    check({tag, " valid"},  {31'd0, valid_o},  {31'd0, e_v});
    check({tag, " halted"}, {31'd0, halted_o}, {31'd0, e_h});
    check({tag, " count"},  count_o,        e_cnt);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        rst, run, stall, flush, src, we;
    logic [31:0] tgt;
    logic [7:0]  wa;
    logic [31:0] wd;
    logic [31:0] e_pc, e_ins;
    logic        e_v, e_h;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(logic r, logic rn, logic st, logic fl, logic sr, logic [31:0] tg,
                              logic we, logic [7:0] wa, logic [31:0] wd,
                              logic [31:0] ep, logic [31:0] ei, logic ev, logic eh, logic [31:0] ec);
    vec_t v;
    v.rst = r; v.run = rn; v.stall = st; v.flush = fl; v.src = sr; v.tgt = tg;
    v.we = we; v.wa = wa; v.wd = wd;
    v.e_pc = ep; v.e_ins = ei; v.e_v = ev; v.e_h = eh; v.e_cnt = ec;
    tbl.push_back(v);
  endfunction

  task automatic idle_inputs();
    rst = 0; run = 0; stall = 0; flush = 0; pc_src = 0; wr_en = 0;
    pc_target = 0; wr_addr = 0; wr_data = 0;
  endtask

  initial begin
    idle_inputs();

    //   rst run stl fl src tgt      we wa  wd            | pc     instr        v h cnt
    // Program with HALT in word 3
    add(1,0,0,0,0,32'h0,   0,8'd0, 32'h0,        32'h0,  32'h0,        0,0,0);
    add(0,0,0,0,0,32'h0,   1,8'd0, 32'h20010005, 32'h0,  32'h0,        0,0,0);
    add(0,0,0,0,0,32'h0,   1,8'd1, 32'h20020007, 32'h0,  32'h0,        0,0,0);
    add(0,0,0,0,0,32'h0,   1,8'd2, 32'h00221820, 32'h0,  32'h0,        0,0,0);
    add(0,0,0,0,0,32'h0,   1,8'd3, HALT,         32'h0,  32'h0,        0,0,0);
    add(0,1,0,0,0,32'h0,   0,8'd0, 32'h0,        32'h0,  32'h0,        0,0,0);
    add(0,0,0,0,0,32'h0,   0,8'd0, 32'h0,        32'd4,  32'h20010005, 1,0,1);
    add(0,0,0,0,0,32'h0,   0,8'd0, 32'h0,        32'd8,  32'h20020007, 1,0,2);
    add(0,0,0,0,0,32'h0,   0,8'd0, 32'h0,        32'd12, 32'h00221820, 1,0,3);
    add(0,0,0,0,0,32'h0,   0,8'd0, 32'h0,        32'd16, HALT,         1,1,4);
    add(0,0,0,0,0,32'h0,   0,8'd0, 32'h0,        32'h0,  32'h0,        0,1,4);
    // HALTED ignores run/redirect/flush/write
    add(0,1,0,1,1,32'h40,  1,8'd0, 32'h0,        32'h0,  32'h0,        0,1,4);
    // Reload: words 3..5 and 16
    add(1,0,0,0,0,32'h0,   0,8'd0, 32'h0,        32'h0,  32'h0,        0,0,0);
    add(0,0,0,0,0,32'h0,   1,8'd3, 32'h00000033, 32'h0,  32'h0,        0,0,0);
    add(0,0,0,0,0,32'h0,   1,8'd4, 32'h00000044, 32'h0,  32'h0,        0,0,0);
    add(0,0,0,0,0,32'h0,   1,8'd5, HALT,         32'h0,  32'h0,        0,0,0);
    add(0,0,0,0,0,32'h0,   1,8'd16,32'h16161616, 32'h0,  32'h0,        0,0,0);
    add(0,1,0,0,0,32'h0,   0,8'd0, 32'h0,        32'h0,  32'h0,        0,0,0);
    add(0,0,0,0,0,32'h0,   0,8'd0, 32'h0,        32'd4,  32'h20010005, 1,0,1);
    add(0,0,0,0,0,32'h0,   0,8'd0, 32'h0,        32'd8,  32'h20020007, 1,0,2);
    // Stall two cycles with PC=8
    add(0,0,1,0,0,32'h0,   0,8'd0, 32'h0,        32'd8,  32'h20020007, 1,0,3);
    add(0,0,1,0,0,32'h0,   0,8'd0, 32'h0,        32'd8,  32'h20020007, 1,0,4);
    add(0,0,0,0,0,32'h0,   0,8'd0, 32'h0,        32'd12, 32'h00221820, 1,0,5);
    // Redirect + flush + stall to misaligned 0x43
    add(0,0,1,1,1,32'h43,  0,8'd0, 32'h0,        32'h0,  32'h0,        0,0,6);
    add(0,0,0,0,0,32'h0,   0,8'd0, 32'h0,        32'h44, 32'h16161616, 1,0,7);
    // Wrap: target 0x400 reads word 0
    add(0,0,0,1,1,32'h400, 0,8'd0, 32'h0,        32'h0,  32'h0,        0,0,8);
    add(0,0,0,0,0,32'h0,   0,8'd0, 32'h0,        32'h404,32'h20010005, 1,0,9);
    // Write during RUN must be ignored
    add(0,0,0,0,0,32'h0,   1,8'd0, 32'hDEADBEEF, 32'h408,32'h20020007, 1,0,10);
    // HALT in a flushed slot does not halt
    add(0,0,0,1,1,32'h14,  0,8'd0, 32'h0,        32'h0,  32'h0,        0,0,11);
    add(0,0,0,1,1,32'h0,   0,8'd0, 32'h0,        32'h0,  32'h0,        0,0,12);
    add(0,0,0,0,0,32'h0,   0,8'd0, 32'h0,        32'd4,  32'h20010005, 1,0,13);
    // Reset mid-run overrides run and write; rerun
    add(1,1,0,0,0,32'h0,   1,8'd0, 32'h00000BAD, 32'h0,  32'h0,        0,0,0);
    add(0,1,0,0,0,32'h0,   0,8'd0, 32'h0,        32'h0,  32'h0,        0,0,0);
    add(0,0,0,0,0,32'h0,   0,8'd0, 32'h0,        32'd4,  32'h20010005, 1,0,1);
    add(0,0,0,0,0,32'h0,   0,8'd0, 32'h0,        32'd8,  32'h20020007, 1,0,2);
    add(0,0,0,0,0,32'h0,   0,8'd0, 32'h0,        32'd12, 32'h00221820, 1,0,3);
    add(0,0,0,0,0,32'h0,   0,8'd0, 32'h0,        32'd16, 32'h00000033, 1,0,4);
    add(0,0,0,0,0,32'h0,   0,8'd0, 32'h0,        32'd20, 32'h00000044, 1,0,5);
    // Stalled HALT does not halt; released HALT does
    add(0,0,1,0,0,32'h0,   0,8'd0, 32'h0,        32'd20, 32'h00000044, 1,0,6);
    add(0,0,0,0,0,32'h0,   0,8'd0, 32'h0,        32'd24, HALT,         1,1,7);
    // Stall in HALTED holds the HALT, then bubbles
    add(0,0,1,0,0,32'h0,   0,8'd0, 32'h0,        32'd24, HALT,         1,1,7);
    add(0,0,0,0,0,32'h0,   0,8'd0, 32'h0,        32'h0,  32'h0,        0,1,7);

    repeat (2) @(posedge clk);
    #1;
    foreach (tbl[i]) begin
      rst = tbl[i].rst; run = tbl[i].run; stall = tbl[i].stall; flush = tbl[i].flush;
      pc_src = tbl[i].src; pc_target = tbl[i].tgt;
      wr_en = tbl[i].we; wr_addr = tbl[i].wa; wr_data = tbl[i].wd;
      tick();
      check_outs($sformatf("row%0d", i), tbl[i].e_pc, tbl[i].e_ins,
                 tbl[i].e_v, tbl[i].e_h, tbl[i].e_cnt);
    end

    // ---------------- randomized phase ----------------
    idle_inputs();
    rst = 1;
    tick();
    check_outs("rnd reset", 32'h0, 32'h0, 0, 0, 32'h0);
    rst = 0;
    // Fill the whole memory so the model and DUT agree on every word.
    for (int a = 0; a < 256; a++) begin
      wr_en = 1; wr_addr = 8'(a);
      wr_data = ($urandom_range(0, 19) == 0) ? HALT : $urandom;
      tick();
    end
    wr_en = 0;
    for (int c = 0; c < 1500; c++) begin
      rst     = ($urandom_range(0, 99) < 2);
      run     = ($urandom_range(0, 3) == 0);
      stall   = ($urandom_range(0, 3) == 0);
      flush   = ($urandom_range(0, 6) == 0);
      pc_src  = flush && ($urandom_range(0, 1) == 1);
      pc_target = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 127)) : $urandom;
      wr_en   = ($urandom_range(0, 2) == 0);
      wr_addr = 8'($urandom_range(0, 255));
      wr_data = ($urandom_range(0, 7) == 0) ? HALT : $urandom;
      tick();
      check_outs($sformatf("rnd%0d", c), m_opc, m_oins, m_ov, m_halted, m_cnt);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
